vga_emulator: RTL and testbench

Behavioural-grade VGA display sink that sits beside the decompressor in the top-level simulation environment. On a `start` pulse it scans one frame with standard VGA horizontal and vertical timing. It generates sync and data-enable, samples the 8-bit `r`/`g`/`b` pixel bus during the active region, and accumulates a pixel count and a checksum so a bench can judge the decoded image. Synthesizable; no file I/O.

---
 rtl/vga_emulator.sv | 120 ++++++++++++
 tb/tb_vga_emulator.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/vga_emulator.sv
// VGA display sink: scans one frame per start pulse, generates sync/de and
// accumulates a pixel count and a {r,g,b} checksum over the active region.
module vga_emulator #(
  parameter int unsigned H_ACTIVE = 320,
  parameter int unsigned H_FP     = 8,
  parameter int unsigned H_SYNC   = 48,
  parameter int unsigned H_BP     = 24,
  parameter int unsigned V_ACTIVE = 240,
  parameter int unsigned V_FP     = 2,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [15:0] x,
  output logic [15:0] y,
  output logic [31:0] pixel_count,
  output logic [31:0] checksum,
  output logic        frame_done
);

  localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START   = H_ACTIVE + H_FP;
  localparam int unsigned HS_END     = HS_START + H_SYNC;
  localparam int unsigned VS_START   = V_ACTIVE + V_FP;
  localparam int unsigned VS_END     = VS_START + V_SYNC;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t      state_q, state_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [31:0] pix_q, pix_d;
  logic [31:0] sum_q, sum_d;
  logic        done_q, done_d;
  logic        scan_c;
  logic        de_c;

  // Timing decodes from registered counters and state
  assign scan_c = (state_q == SCAN);
  assign de_c   = scan_c && (x_q < 16'(H_ACTIVE)) && (y_q < 16'(V_ACTIVE));

  assign busy        = scan_c;
  assign de          = de_c;
  assign hsync       = !(scan_c && (x_q >= 16'(HS_START)) && (x_q < 16'(HS_END)));
  assign vsync       = !(scan_c && (y_q >= 16'(VS_START)) && (y_q < 16'(VS_END)));
  assign x           = x_q;
  assign y           = y_q;
  assign pixel_count = pix_q;
  assign checksum    = sum_q;
  assign frame_done  = done_q;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    pix_d   = pix_q;
    sum_d   = sum_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          x_d     = 16'd0;
          y_d     = 16'd0;
          pix_d   = 32'd0;
          sum_d   = 32'd0;
        end
      end
      SCAN: begin
        if (de_c) begin
          sum_d = sum_q + 32'({r, g, b});
          pix_d = pix_q + 32'd1;
        end
        if (x_q == 16'(H_TOTAL - 1)) begin
          x_d = 16'd0;
          if (y_q == 16'(V_TOTAL - 1)) begin
            // Last cycle of the frame: return to idle with counters cleared
            state_d = IDLE;
            y_d     = 16'd0;
            done_d  = 1'b1;
          end else begin
            y_d = y_q + 16'd1;
          end
        end else begin
          x_d = x_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      x_q     <= 16'd0;
      y_q     <= 16'd0;
      pix_q   <= 32'd0;
      sum_q   <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pix_q   <= pix_d;
      sum_q   <= sum_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_vga_emulator.sv
// Directed bench for vga_emulator using an 8x6 timing (48-cycle frame).
module tb_vga_emulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  r, g, b;
  logic        busy, hsync, vsync, de, frame_done;
  logic [15:0] x, y;
  logic [31:0] pixel_count, checksum;

  int checks = 0;
  int passed = 0;

  vga_emulator #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .r(r), .g(g), .b(b),
    .busy(busy), .hsync(hsync), .vsync(vsync), .de(de),
    .x(x), .y(y), .pixel_count(pixel_count), .checksum(checksum),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rgb(input logic [23:0] v);
    {r, g, b} = v;
  endtask

  task automatic check_idle_reset();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_de", 32'(de), 32'd0);
    check("rst_hsync", 32'(hsync), 32'd1);
    check("rst_vsync", 32'(vsync), 32'd1);
    check("rst_x", 32'(x), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_pix", pixel_count, 32'd0);
    check("rst_sum", checksum, 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
  endtask

  // Called just after the start edge; walks the 48 SCAN cycles checking timing.
  task automatic scan_frame(input bit ramp, input bit restart_at_20);
    int ex, ey, idx;
    bit ede;
    idx = 0;
    for (int k = 0; k < 48; k++) begin
      ex  = k % 8;
      ey  = k / 8;
      ede = (ex < 4) && (ey < 3);
      check("scan_busy", 32'(busy), 32'd1);
      check("scan_x", 32'(x), 32'(ex));
      check("scan_y", 32'(y), 32'(ey));
      check("scan_de", 32'(de), 32'(ede));
      check("scan_hsync", 32'(hsync), (ex == 5 || ex == 6) ? 32'd0 : 32'd1);
      check("scan_vsync", 32'(vsync), (ey == 4) ? 32'd0 : 32'd1);
      check("scan_done", 32'(frame_done), 32'd0);
      if (ramp) begin
        if (ede) begin
          set_rgb(24'(idx));
          idx++;
        end else begin
          set_rgb(24'hABCDEF);
        end
      end
      start = restart_at_20 && (k == 20);
      step();
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    set_rgb(24'h000000);
    #2;
    check_idle_reset();
    step();
    reset = 1'b1;
    step();
    check("idle_busy", 32'(busy), 32'd0);

    // Constant pixel frame with an ignored restart at cycle 20
    set_rgb(24'h010203);
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_pix_clr", pixel_count, 32'd0);
    scan_frame(1'b0, 1'b1);
    check("c_done", 32'(frame_done), 32'd1);
    check("c_busy", 32'(busy), 32'd0);
    check("c_pix", pixel_count, 32'd12);
    check("c_sum", checksum, 32'h000C1824);
    check("c_x", 32'(x), 32'd0);
    check("c_y", 32'(y), 32'd0);
    step();
    check("c_done_pulse", 32'(frame_done), 32'd0);
    check("c_sum_hold", checksum, 32'h000C1824);
    check("c_pix_hold", pixel_count, 32'd12);
    step();

    // Ramp frame: only active pixels contribute
    start = 1'b1;
    step();
    start = 1'b0;
    check("r_sum_clr", checksum, 32'd0);
    scan_frame(1'b1, 1'b0);
    check("r_done", 32'(frame_done), 32'd1);
    check("r_pix", pixel_count, 32'd12);
    check("r_sum", checksum, 32'd66);

    // Back-to-back start in the frame_done cycle
    set_rgb(24'hFFFFFF);
    start = 1'b1;
    step();
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_sum", checksum, 32'd0);
    check("b2b_pix", pixel_count, 32'd0);
    check("b2b_done", 32'(frame_done), 32'd0);
    check("b2b_x", 32'(x), 32'd0);
    for (int k = 0; k < 10; k++) step();
    check("b2b_mid_x", 32'(x), 32'd2);
    check("b2b_mid_y", 32'(y), 32'd1);
    check("b2b_mid_pix", pixel_count, 32'd6);

    // Asynchronous reset mid-frame, checked before the next edge
    reset = 1'b0;
    #1;
    check_idle_reset();
    step();
    reset = 1'b1;
    step();
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
